// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU op codes, exception cause codes,
// ex_status bit positions, EX/MEM payload and the EX/MEM FSM state type.
package pipe_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned STAT_W  = 8;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned CTL_W   = 3;
  localparam int unsigned CAUSE_W = 5;
  localparam int unsigned CNT_W   = 16;

  // ALU control codes that can raise an exception
  localparam logic [OP_W-1:0] ALU_DIV = 4'd4;
  localparam logic [OP_W-1:0] ALU_MUL = 4'd5;
  localparam logic [OP_W-1:0] ALU_LW  = 4'd12;
  localparam logic [OP_W-1:0] ALU_SW  = 4'd13;

  // Exception cause codes
  localparam logic [CAUSE_W-1:0] CAUSE_NONE = 5'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ADEL = 5'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_ADES = 5'd5;
  localparam logic [CAUSE_W-1:0] CAUSE_OV   = 5'd12;
  localparam logic [CAUSE_W-1:0] CAUSE_DIVZ = 5'd15;

  // ex_status bit positions
  localparam int unsigned STAT_ZERO  = 7;
  localparam int unsigned STAT_MULOV = 6;
  localparam int unsigned STAT_CARRY = 5;
  localparam int unsigned STAT_NEG   = 4;
  localparam int unsigned STAT_ALIGN = 3;
  localparam int unsigned STAT_DIVZ  = 2;

  // ex_ctl bit positions: {mem_read, mem_write, reg_write}
  localparam int unsigned CTL_MEM_READ  = 2;
  localparam int unsigned CTL_MEM_WRITE = 1;
  localparam int unsigned CTL_REG_WRITE = 0;

  // EX/MEM FSM state
  typedef logic [0:0] state_t;
  localparam state_t ST_RUN  = 1'b0;
  localparam state_t ST_TRAP = 1'b1;

  // Data carried from EX into MEM
  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  store_data;
    logic [RD_W-1:0]  rd;
    logic [CTL_W-1:0] ctl;
  } mem_payload_t;

endpackage

// File: rtl/exc_detect.sv
// Combinational fault classifier for the instruction in EX.
// Priority: address errors (AdEL/AdES) > divide-by-zero > multiply overflow.
module exc_detect
  import pipe_pkg::*;
(
  input  logic [OP_W-1:0]    op_i,
  input  logic [STAT_W-1:0]  status_i,
  input  logic [CTL_W-1:0]   ctl_i,
  output logic               fault_c_o,
  output logic [CAUSE_W-1:0] cause_c_o
);

  logic adel;
  logic ades;
  logic divz;
  logic ovf;
  logic unused_inputs;

  assign adel = (op_i == ALU_LW) && ctl_i[CTL_MEM_READ]  && !status_i[STAT_ALIGN];
  assign ades = (op_i == ALU_SW) && ctl_i[CTL_MEM_WRITE] && !status_i[STAT_ALIGN];
  assign divz = (op_i == ALU_DIV) && status_i[STAT_DIVZ];
  assign ovf  = (op_i == ALU_MUL) && status_i[STAT_MULOV];

  // Status/ctl bits that never contribute to a fault
  assign unused_inputs = ^{status_i[STAT_ZERO], status_i[STAT_CARRY],
                           status_i[STAT_NEG], status_i[1:0], ctl_i[CTL_REG_WRITE]};

  // Priority encode the fault sources into a single cause
  always_comb begin
    fault_c_o = 1'b0;
    cause_c_o = CAUSE_NONE;
    if (adel) begin
      fault_c_o = 1'b1;
      cause_c_o = CAUSE_ADEL;
    end else if (ades) begin
      fault_c_o = 1'b1;
      cause_c_o = CAUSE_ADES;
    end else if (divz) begin
      fault_c_o = 1'b1;
      cause_c_o = CAUSE_DIVZ;
    end else if (ovf) begin
      fault_c_o = 1'b1;
      cause_c_o = CAUSE_OV;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with precise exception capture.
// RUN: captures EX each unstalled cycle (bubble when ex_valid=0); a faulting
// instruction is squashed, its PC/cause latched, flush pulsed, and the stage
// enters TRAP. TRAP: no captures until an unstalled eret returns to RUN.
// Optional build macro EXC_COUNT_EN adds a saturating 16-bit trap counter
// on output exc_count.
module ex_mem_stage
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                eret,
  input  logic                ex_valid,
  input  logic [31:0]         ex_pc,
  input  logic [3:0]          ex_alu_op,
  input  logic [31:0]         ex_result,
  input  logic [7:0]          ex_status,
  input  logic [31:0]         ex_store_data,
  input  logic [4:0]          ex_rd,
  input  logic [2:0]          ex_ctl,
  output logic                mem_valid,
  output logic [31:0]         mem_result,
  output logic [31:0]         mem_store_data,
  output logic [4:0]          mem_rd,
  output logic [2:0]          mem_ctl,
  output logic                exc_req,
  output logic [4:0]          exc_cause,
  output logic [31:0]         epc,
  output logic                flush
`ifdef EXC_COUNT_EN
  ,
  output logic [15:0]         exc_count
`endif
);

  state_t             state_q,     state_d;
  mem_payload_t       payload_q,   payload_d;
  logic               mem_valid_q, mem_valid_d;
  logic               exc_req_q,   exc_req_d;
  logic [CAUSE_W-1:0] cause_q,     cause_d;
  logic [XLEN-1:0]    epc_q,       epc_d;
  logic               flush_q,     flush_d;

  logic               fault_c;
  logic [CAUSE_W-1:0] cause_c;

  exc_detect u_exc_detect (
    .op_i      (ex_alu_op),
    .status_i  (ex_status),
    .ctl_i     (ex_ctl),
    .fault_c_o (fault_c),
    .cause_c_o (cause_c)
  );

  // Next-state and output decode; stall freezes everything except the flush pulse
  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    mem_valid_d = mem_valid_q;
    exc_req_d   = exc_req_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    flush_d     = 1'b0;

    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (!ex_valid) begin
            mem_valid_d   = 1'b0;
            payload_d.ctl = '0;
          end else if (fault_c) begin
            mem_valid_d   = 1'b0;
            payload_d.ctl = '0;
            exc_req_d     = 1'b1;
            cause_d       = cause_c;
            epc_d         = ex_pc;
            flush_d       = 1'b1;
            state_d       = ST_TRAP;
          end else begin
            mem_valid_d          = 1'b1;
            payload_d.result     = ex_result;
            payload_d.store_data = ex_store_data;
            payload_d.rd         = ex_rd;
            payload_d.ctl        = ex_ctl;
          end
        end
        ST_TRAP: begin
          mem_valid_d   = 1'b0;
          payload_d.ctl = '0;
          if (eret) begin
            exc_req_d = 1'b0;
            state_d   = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      payload_q   <= '0;
      mem_valid_q <= 1'b0;
      exc_req_q   <= 1'b0;
      cause_q     <= CAUSE_NONE;
      epc_q       <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      mem_valid_q <= mem_valid_d;
      exc_req_q   <= exc_req_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      flush_q     <= flush_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_result     = payload_q.result;
  assign mem_store_data = payload_q.store_data;
  assign mem_rd         = payload_q.rd;
  assign mem_ctl        = payload_q.ctl;
  assign exc_req        = exc_req_q;
  assign exc_cause      = cause_q;
  assign epc            = epc_q;
  assign flush          = flush_q;

`ifdef EXC_COUNT_EN
  logic             trap_enter_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign trap_enter_c = !stall && (state_q == ST_RUN) && ex_valid && fault_c;

  // Saturating trap counter
  always_comb begin
    cnt_d = cnt_q;
    if (trap_enter_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign exc_count = cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, eret, ex_valid;
  logic [31:0] ex_pc, ex_result, ex_store_data;
  logic [3:0]  ex_alu_op;
  logic [7:0]  ex_status;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_ctl;
  logic        mem_valid, exc_req, flush;
  logic [31:0] mem_result, mem_store_data, epc;
  logic [4:0]  mem_rd, exc_cause;
  logic [2:0]  mem_ctl;
`ifdef EXC_COUNT_EN
  logic [15:0] exc_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .eret(eret), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_alu_op(ex_alu_op), .ex_result(ex_result),
    .ex_status(ex_status), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_ctl(ex_ctl), .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_ctl(mem_ctl),
    .exc_req(exc_req), .exc_cause(exc_cause), .epc(epc), .flush(flush)
`ifdef EXC_COUNT_EN
    , .exc_count(exc_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_trapped;
  bit          m_valid, m_req, m_flush;
  logic [31:0] m_result, m_sd, m_epc;
  logic [4:0]  m_rd, m_cause;
  logic [2:0]  m_ctl;
  int          m_traps;

  // Cause of the highest-priority fault rule that fires (0 = none).
  function automatic logic [4:0] ref_cause(input logic [3:0] op, input logic [7:0] st,
                                           input logic [2:0] ctl);
    logic [3:0] r_op[4]   = '{4'd12, 4'd13, 4'd4, 4'd5};
    logic [4:0] r_code[4] = '{5'd4, 5'd5, 5'd15, 5'd12};
    int         r_rank[4] = '{0, 0, 1, 2};
    int best = 99;
    logic [4:0] c = 5'd0;
    for (int i = 0; i < 4; i++) begin
      bit hit;
      case (i)
        0: hit = ctl[2] && !st[3];
        1: hit = ctl[1] && !st[3];
        2: hit = st[2];
        default: hit = st[6];
      endcase
      if (op == r_op[i] && hit && r_rank[i] < best) begin
        best = r_rank[i];
        c = r_code[i];
      end
    end
    return c;
  endfunction

  task automatic model_reset();
    m_trapped = 0; m_valid = 0; m_req = 0; m_flush = 0;
    m_result = 0; m_sd = 0; m_epc = 0; m_rd = 0; m_cause = 0; m_ctl = 0;
    m_traps = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      logic [4:0] c;
      m_flush = 0;
      if (!stall) begin
        if (m_trapped) begin
          m_valid = 0; m_ctl = 0;
          if (eret) begin m_trapped = 0; m_req = 0; end
        end else if (!ex_valid) begin
          m_valid = 0; m_ctl = 0;
        end else begin
          c = ref_cause(ex_alu_op, ex_status, ex_ctl);
          if (c != 0) begin
            m_valid = 0; m_ctl = 0; m_trapped = 1; m_req = 1; m_flush = 1;
            m_cause = c; m_epc = ex_pc;
            if (m_traps < 16'hFFFF) m_traps++;
          end else begin
            m_valid = 1; m_result = ex_result; m_sd = ex_store_data;
            m_rd = ex_rd; m_ctl = ex_ctl;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("mem_valid", 32'(mem_valid), 32'(m_valid));
      chk("mem_ctl", 32'(mem_ctl), 32'(m_ctl));
      chk("flush", 32'(flush), 32'(m_flush));
      chk("exc_req", 32'(exc_req), 32'(m_req));
      chk("exc_cause", 32'(exc_cause), 32'(m_cause));
      chk("epc", epc, m_epc);
      if (m_valid) begin
        chk("mem_result", mem_result, m_result);
        chk("mem_store_data", mem_store_data, m_sd);
        chk("mem_rd", 32'(mem_rd), 32'(m_rd));
      end
`ifdef EXC_COUNT_EN
      chk("exc_count", 32'(exc_count), 32'(m_traps));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input logic [31:0] pc, input logic [3:0] op,
                       input logic [31:0] res, input logic [7:0] st,
                       input logic [4:0] rd, input logic [2:0] ctl,
                       input bit stl, input bit er);
    ex_valid = v; ex_pc = pc; ex_alu_op = op; ex_result = res; ex_status = st;
    ex_store_data = res ^ 32'hA5A5_0000; ex_rd = rd; ex_ctl = ctl;
    stall = stl; eret = er;
  endtask

  task automatic idle(input bit stl, input bit er);
    drive(1'b0, 32'h0, 4'd0, 32'h0, 8'h08, 5'd0, 3'b000, stl, er);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, "_mem_result"}, mem_result, 32'd0);
    chk({tag, "_mem_sd"}, mem_store_data, 32'd0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_mem_ctl"}, 32'(mem_ctl), 32'd0);
    chk({tag, "_exc_req"}, 32'(exc_req), 32'd0);
    chk({tag, "_exc_cause"}, 32'(exc_cause), 32'd0);
    chk({tag, "_epc"}, epc, 32'd0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
`ifdef EXC_COUNT_EN
    chk({tag, "_exc_count"}, 32'(exc_count), 32'd0);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] ops[5] = '{4'd2, 4'd4, 4'd5, 4'd12, 4'd13};
    model_reset();
    rst_n = 1'b0;
    idle(1'b0, 1'b0);
    #12;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    check_en = 1'b1;

    // Clean ALU op: one-cycle latency, no flush
    drive(1'b1, 32'h10, 4'd2, 32'h0000_0010, 8'h08, 5'd3, 3'b001, 1'b0, 1'b0);
    tick();
    chk("add_valid", 32'(mem_valid), 32'd1);
    chk("add_result", mem_result, 32'h10);
    chk("add_ctl", 32'(mem_ctl), 32'd1);
    chk("add_flush", 32'(flush), 32'd0);

    // Misaligned load -> AdEL
    drive(1'b1, 32'h40, 4'd12, 32'h1002, 8'h00, 5'd4, 3'b101, 1'b0, 1'b0);
    tick();
    chk("adel_flush", 32'(flush), 32'd1);
    chk("adel_cause", 32'(exc_cause), 32'd4);
    chk("adel_epc", epc, 32'h40);
    chk("adel_ctl", 32'(mem_ctl), 32'd0);
    chk("adel_req", 32'(exc_req), 32'd1);
    idle(1'b0, 1'b0);
    tick();
    chk("adel_flush_1cyc", 32'(flush), 32'd0);
    chk("adel_req_held", 32'(exc_req), 32'd1);
    idle(1'b0, 1'b1);
    tick();
    chk("adel_eret", 32'(exc_req), 32'd0);

    // DivZ beats Ov flag; TRAP ignores ex_valid until eret
    drive(1'b1, 32'h100, 4'd4, 32'h7, 8'h44, 5'd5, 3'b001, 1'b0, 1'b0);
    tick();
    chk("divz_cause", 32'(exc_cause), 32'd15);
    drive(1'b1, 32'h104, 4'd2, 32'h99, 8'h08, 5'd6, 3'b001, 1'b0, 1'b0);
    tick();
    tick();
    chk("trap_ignore_valid", 32'(mem_valid), 32'd0);
    chk("trap_epc_held", epc, 32'h100);
    drive(1'b1, 32'h108, 4'd2, 32'h99, 8'h08, 5'd6, 3'b001, 1'b0, 1'b1);
    tick();
    chk("divz_eret_req", 32'(exc_req), 32'd0);
    chk("divz_eret_valid", 32'(mem_valid), 32'd0);
    drive(1'b1, 32'h10C, 4'd2, 32'h55, 8'h08, 5'd7, 3'b001, 1'b0, 1'b0);
    tick();
    chk("resume_valid", 32'(mem_valid), 32'd1);
    chk("resume_result", mem_result, 32'h55);

    // Stalled Ov fault traps only once stall drops
    drive(1'b1, 32'h200, 4'd5, 32'h1, 8'h40, 5'd8, 3'b001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_flush", 32'(flush), 32'd0);
      chk("stall_no_req", 32'(exc_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("ov_flush", 32'(flush), 32'd1);
    chk("ov_cause", 32'(exc_cause), 32'd12);
    chk("ov_epc", epc, 32'h200);
    idle(1'b1, 1'b1);
    tick();
    chk("stall_over_eret", 32'(exc_req), 32'd1);
    idle(1'b0, 1'b1);
    tick();
    chk("ov_eret", 32'(exc_req), 32'd0);

    // Async reset in the middle of TRAP
    drive(1'b1, 32'h300, 4'd13, 32'h3, 8'h00, 5'd9, 3'b010, 1'b0, 1'b0);
    tick();
    chk("ades_cause", 32'(exc_cause), 32'd5);
    idle(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst_n = 1'b1;

    // Two traps after reset
    drive(1'b1, 32'h500, 4'd4, 32'h0, 8'h04, 5'd1, 3'b001, 1'b0, 1'b0);
    tick();
    idle(1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h600, 4'd5, 32'h0, 8'h40, 5'd1, 3'b001, 1'b0, 1'b0);
    tick();
    chk("trap2_epc", epc, 32'h600);
`ifdef EXC_COUNT_EN
    chk("exc_count_2", 32'(exc_count), 32'd2);
`endif
    idle(1'b0, 1'b1);
    tick();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [3:0] op;
      logic [7:0] st;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
      st = 8'($urandom);
      drive($urandom_range(0, 3) != 0, $urandom, op, $urandom, st,
            5'($urandom), 3'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0);
      if (cyc == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rand_rst");
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    idle(1'b0, 1'b0);
    tick();
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
